multi_ctrl_skid_fifo: RTL and testbench

Parametrised multi-destination backward-pipeline buffer: one shared data bus with an N_CH-bit destination mask on each side. Each beat is delivered to every channel in its mask, and each channel may accept in a different cycle. The beat is retired only when all its destination channels have accepted. Up to DEPTH beats are buffered in order. When the buffer is empty, a beat passes through to the output in the same cycle. The block sits between a broadcast producer and N_CH independent consumers on datapath links, cutting the ready timing path.

---
 rtl/multi_ctrl_skid_fifo.sv | 130 +++++++++++++
 tb/tb_multi_ctrl_skid_fifo.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_ctrl_skid_fifo.sv
// Purpose: in-order beat buffer that delivers one shared payload to every channel in a destination mask.
// Latency: zero cycles when empty (bypass); otherwise a beat appears once all beats ahead of it retire.
// Backpressure: f_ready_out is driven only from state (cnt != DEPTH), so there is no combinational path from b_ready_in.
module multi_ctrl_skid_fifo #(
  parameter int DATA_W = 256,
  parameter int N_CH   = 2,
  parameter int DEPTH  = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   f_valid_in,
  input  logic [DATA_W-1:0] f_data_in,
  output logic [N_CH-1:0]   f_ready_out,
  output logic [N_CH-1:0]   b_valid_out,
  output logic [DATA_W-1:0] b_data_out,
  input  logic [N_CH-1:0]   b_ready_in,
  output logic [CNT_W-1:0]  level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Payload and per-entry mask of channels that still owe an accept.
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [N_CH-1:0]   rem_q  [DEPTH];
  logic [N_CH-1:0]   rem_d  [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              empty;
  logic              full;
  logic              acc_rdy;
  logic              push_hs;
  logic              pop;
  logic              wr_en;
  logic [N_CH-1:0]   head_rem;
  logic [N_CH-1:0]   head_rem_nxt;
  logic [N_CH-1:0]   bypass_res;
  logic [N_CH-1:0]   wr_rem;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Status decode and outputs: bypass the offered beat when empty, else present the head entry.
  always_comb begin
    empty        = (cnt_q == '0);
    full         = (cnt_q == FULL_CNT);
    acc_rdy      = ~full & ~rst;
    push_hs      = (|f_valid_in) & acc_rdy;
    head_rem     = rem_q[rd_ptr_q];
    head_rem_nxt = head_rem & ~b_ready_in;
    bypass_res   = f_valid_in & ~b_ready_in;

    f_ready_out  = {N_CH{acc_rdy}};
    level        = rst ? '0 : cnt_q;
    if (empty) begin
      b_valid_out = f_valid_in & f_ready_out;
      b_data_out  = f_data_in;
    end else begin
      b_valid_out = rst ? '0 : head_rem;
      b_data_out  = data_q[rd_ptr_q];
    end
  end

  // Next-state: bypass stores only the channels that missed it; buffered mode pushes the full mask behind the head.
  always_comb begin
    data_d   = data_q;
    rem_d    = rem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    pop      = 1'b0;
    wr_en    = 1'b0;
    wr_rem   = '0;

    if (empty) begin
      wr_en  = push_hs & (|bypass_res);
      wr_rem = bypass_res;
    end else begin
      rem_d[rd_ptr_q] = head_rem_nxt;
      pop             = ~(|head_rem_nxt);
      wr_en           = push_hs;
      wr_rem          = f_valid_in;
    end

    // Tail never aliases the head here: a push needs cnt < DEPTH, and cnt > 0 puts them apart.
    if (wr_en) begin
      data_d[wr_ptr_q] = f_data_in;
      rem_d[wr_ptr_q]  = wr_rem;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state with synchronous reset; all pending masks are dropped so stale beats never reappear.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
    end
  end

  // Payload storage is not reset; a zero rem mask already marks an entry as invalid.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

endmodule

// File: tb/tb_multi_ctrl_skid_fifo.sv
// Purpose: bench for multi_ctrl_skid_fifo with a queue-based beat model and a per-channel delivery scoreboard.
// Latency: outputs are compared mid-cycle against the model; the model advances on each rising edge.
// Backpressure: the producer holds its beat until the model says it was accepted.
module tb_multi_ctrl_skid_fifo;

  localparam int AN = 2;
  localparam int AD = 2;
  localparam int BW = 16;
  localparam int BN = 4;
  localparam int BD = 3;

  typedef struct packed {
    logic [255:0] d;
    logic [3:0]   m;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [AN-1:0]  a_fv, a_fr, a_bv, a_br;
  logic [255:0]   a_fd, a_bd;
  logic [1:0]     a_lvl;
  logic [BN-1:0]  b_fv, b_fr, b_bv, b_br;
  logic [BW-1:0]  b_fd, b_bd;
  logic [1:0]     b_lvl;

  multi_ctrl_skid_fifo #(.DATA_W(256), .N_CH(AN), .DEPTH(AD)) dut_a (
    .clk(clk), .rst(rst), .f_valid_in(a_fv), .f_data_in(a_fd), .f_ready_out(a_fr),
    .b_valid_out(a_bv), .b_data_out(a_bd), .b_ready_in(a_br), .level(a_lvl));

  multi_ctrl_skid_fifo #(.DATA_W(BW), .N_CH(BN), .DEPTH(BD)) dut_b (
    .clk(clk), .rst(rst), .f_valid_in(b_fv), .f_data_in(b_fd), .f_ready_out(b_fr),
    .b_valid_out(b_bv), .b_data_out(b_bd), .b_ready_in(b_br), .level(b_lvl));

  beat_t qa[$];
  beat_t qb[$];
  int vectors = 0;
  int miscompares = 0;
  logic b_took;
  logic [BW-1:0] acc_dat [64];
  logic [BN-1:0] acc_msk [64];
  int acc_n = 0;
  int ch_pos [BN];
  int sent;
  logic pending;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_a();
    logic rdy;
    logic [AN-1:0] ebv;
    logic [255:0] ed;
    rdy = !rst && (qa.size() < AD);
    ebv = '0;
    ed  = '0;
    if (!rst) begin
      if (qa.size() == 0) begin
        ebv = a_fv & {AN{rdy}};
        ed  = a_fd;
      end else begin
        ebv = qa[0].m[AN-1:0];
        ed  = qa[0].d;
      end
    end
    chk("a_ready", 256'(a_fr), 256'({AN{rdy}}));
    chk("a_valid", 256'(a_bv), 256'(ebv));
    chk("a_level", 256'(a_lvl), rst ? 256'(0) : 256'(qa.size()));
    if (ebv != '0) chk("a_data", a_bd, ed);
  endtask

  task automatic check_b();
    logic rdy;
    logic [BN-1:0] ebv;
    logic [BW-1:0] ed;
    rdy = !rst && (qb.size() < BD);
    ebv = '0;
    ed  = '0;
    if (!rst) begin
      if (qb.size() == 0) begin
        ebv = b_fv & {BN{rdy}};
        ed  = b_fd;
      end else begin
        ebv = qb[0].m;
        ed  = qb[0].d[BW-1:0];
      end
    end
    chk("b_ready", 256'(b_fr), 256'({BN{rdy}}));
    chk("b_valid", 256'(b_bv), 256'(ebv));
    chk("b_level", 256'(b_lvl), rst ? 256'(0) : 256'(qb.size()));
    if (ebv != '0) chk("b_data", 256'(b_bd), 256'(ed));
    b_took = (b_fv != '0) && rdy;
    if (b_took && acc_n < 64) begin
      acc_dat[acc_n] = b_fd;
      acc_msk[acc_n] = b_fv;
      acc_n++;
    end
    for (int c = 0; c < BN; c++) begin
      if (b_bv[c] && b_br[c]) begin
        int k;
        logic found;
        k = ch_pos[c];
        while (k < acc_n && !acc_msk[k][c]) k++;
        found = (k < acc_n);
        chk($sformatf("sb_found_ch%0d", c), 256'(found), 256'(1));
        if (found) begin
          chk($sformatf("sb_data_ch%0d", c), 256'(b_bd), 256'(acc_dat[k]));
          ch_pos[c] = k + 1;
        end
      end
    end
  endtask

  task automatic update_models();
    beat_t h;
    logic push;
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      push = (a_fv != '0) && (qa.size() < AD);
      if (qa.size() == 0) begin
        if (push && ((a_fv & ~a_br) != '0)) qa.push_back({a_fd, 2'b00, a_fv & ~a_br});
      end else begin
        h = qa[0];
        h.m = h.m & {2'b00, ~a_br};
        qa[0] = h;
        if (push) qa.push_back({a_fd, 2'b00, a_fv});
        if (h.m == '0) void'(qa.pop_front());
      end
      push = (b_fv != '0) && (qb.size() < BD);
      if (qb.size() == 0) begin
        if (push && ((b_fv & ~b_br) != '0)) qb.push_back({240'(0), b_fd, b_fv & ~b_br});
      end else begin
        h = qb[0];
        h.m = h.m & ~b_br;
        qb[0] = h;
        if (push) qb.push_back({240'(0), b_fd, b_fv});
        if (h.m == '0) void'(qb.pop_front());
      end
    end
  endtask

  task automatic eval();
    #3;
    check_a();
    check_b();
  endtask

  task automatic adv();
    @(posedge clk);
    update_models();
    #1;
  endtask

  task automatic drive_a(input logic [AN-1:0] fv, input logic [7:0] fd, input logic [AN-1:0] br);
    a_fv = fv;
    a_fd = 256'(fd);
    a_br = br;
  endtask

  initial begin
    for (int c = 0; c < BN; c++) ch_pos[c] = 0;
    rst = 1'b1;
    drive_a(2'b00, 8'h00, 2'b00);
    b_fv = '0; b_fd = '0; b_br = '0;
    eval(); adv();
    eval(); adv();

    // First cycle out of reset: ready high, empty.
    rst = 1'b0;
    eval();
    chk("post_rst_ready", 256'(a_fr), 256'(2'b11));
    chk("post_rst_level", 256'(a_lvl), 256'(0));
    adv();

    // Bypass with all consumers ready.
    drive_a(2'b11, 8'hA5, 2'b11);
    eval();
    chk("bypass_valid", 256'(a_bv), 256'(2'b11));
    chk("bypass_data", a_bd, 256'(8'hA5));
    adv();
    drive_a(2'b00, 8'h00, 2'b11);
    eval();
    chk("bypass_level", 256'(a_lvl), 256'(0));
    chk("idle_valid", 256'(a_bv), 256'(0));
    adv();

    // Split accept: ch0 now, ch1 three cycles later.
    drive_a(2'b11, 8'h11, 2'b01);
    eval(); adv();
    drive_a(2'b00, 8'h00, 2'b00);
    eval();
    chk("split_valid", 256'(a_bv), 256'(2'b10));
    chk("split_data", a_bd, 256'(8'h11));
    chk("split_level", 256'(a_lvl), 256'(1));
    adv();
    eval(); adv();
    a_br = 2'b10;
    eval(); adv();
    a_br = 2'b00;
    eval();
    chk("split_retired", 256'(a_lvl), 256'(0));
    adv();

    // Fill and backpressure.
    drive_a(2'b11, 8'h01, 2'b00); eval(); adv();
    drive_a(2'b11, 8'h02, 2'b00); eval(); adv();
    drive_a(2'b11, 8'h03, 2'b00); eval();
    chk("full_level", 256'(a_lvl), 256'(2));
    chk("full_ready", 256'(a_fr), 256'(0));
    chk("full_head", a_bd, 256'(8'h01));
    adv();
    eval(); adv();
    a_br = 2'b11;
    eval();
    chk("full_pop_ready", 256'(a_fr), 256'(0));
    adv();
    a_br = 2'b00;
    eval();
    chk("reopen_ready", 256'(a_fr), 256'(2'b11));
    chk("order_2", a_bd, 256'(8'h02));
    adv();
    drive_a(2'b00, 8'h00, 2'b11);
    eval(); adv();
    eval();
    chk("order_3", a_bd, 256'(8'h03));
    adv();
    eval();
    chk("fill_drained", 256'(a_lvl), 256'(0));
    adv();

    // Simultaneous push and pop at level 1.
    drive_a(2'b11, 8'h44, 2'b01); eval(); adv();
    drive_a(2'b11, 8'h55, 2'b10); eval(); adv();
    drive_a(2'b00, 8'h00, 2'b00);
    eval();
    chk("pp_level", 256'(a_lvl), 256'(1));
    chk("pp_mask", 256'(a_bv), 256'(2'b11));
    chk("pp_data", a_bd, 256'(8'h55));
    adv();
    a_br = 2'b11; eval(); adv();

    // Reset with two buffered beats.
    drive_a(2'b11, 8'h66, 2'b00); eval(); adv();
    drive_a(2'b11, 8'h77, 2'b00); eval(); adv();
    drive_a(2'b00, 8'h00, 2'b00);
    eval();
    chk("pre_rst_level", 256'(a_lvl), 256'(2));
    adv();
    rst = 1'b1;
    eval();
    chk("rst_valid", 256'(a_bv), 256'(0));
    chk("rst_ready", 256'(a_fr), 256'(0));
    adv();
    rst = 1'b0;
    a_br = 2'b11;
    eval();
    chk("after_rst_level", 256'(a_lvl), 256'(0));
    chk("after_rst_valid", 256'(a_bv), 256'(0));
    adv();
    drive_a(2'b11, 8'h88, 2'b11);
    eval();
    chk("after_rst_data", a_bd, 256'(8'h88));
    adv();
    drive_a(2'b00, 8'h00, 2'b00);

    // Randomized traffic through the 4-channel, depth-3 instance.
    sent = 0;
    pending = 1'b0;
    for (int cyc = 0; cyc < 3000 && sent < 30; cyc++) begin
      if (!pending) begin
        if ($urandom_range(0, 3) != 0) begin
          b_fv = 4'($urandom_range(1, 15));
          b_fd = 16'($urandom);
          pending = 1'b1;
        end else begin
          b_fv = '0;
          b_fd = 16'($urandom);
        end
      end
      b_br = 4'($urandom);
      eval();
      adv();
      if (b_took) begin
        pending = 1'b0;
        sent++;
        b_fv = '0;
      end
    end
    chk("rand_sent", 256'(sent), 256'(30));
    b_fv = '0;
    for (int i = 0; i < 200 && qb.size() != 0; i++) begin
      b_br = 4'hF;
      eval();
      adv();
    end
    b_br = '0;
    eval();
    chk("rand_drain_level", 256'(b_lvl), 256'(0));
    for (int c = 0; c < BN; c++) begin
      int left;
      left = 0;
      for (int k = ch_pos[c]; k < acc_n; k++) if (acc_msk[k][c]) left++;
      chk($sformatf("sb_left_ch%0d", c), 256'(left), 256'(0));
    end
    adv();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
